vram_dma_ctrl: RTL

Block-fill engine and write-port arbiter for the tile layer VRAMs (40x30 tile maps, layers L1/L2). The Z80 programs a start index, length and fill value through a small register window, then sets GO. The block then streams one write per cpu_clk into the selected layer(s), yielding the port to direct CPU VRAM writes whenever they occur. It sits between the address decoder and the CPU-side write ports of both layer VRAMs, replacing their direct write enables.

---
 rtl/vram_dma_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/vram_dma_ctrl.sv
// vram_dma_ctrl: block-fill DMA engine and CPU/DMA write-port arbiter for L1/L2 tile VRAMs.
// Optional macro VRAM_DMA_INC_EN makes CTRL bit3 (INC) store and drive an incrementing fill.
module vram_dma_ctrl #(
    parameter int VRAM_DEPTH = 1200,
    parameter int ADDR_W     = 11
) (
    input  logic              cpu_clk,
    input  logic              rst,
    input  logic [15:0]       address_bus,
    input  logic [7:0]        data_bus,
    input  logic              z80_write,
    input  logic              dma_cs,
    output logic [7:0]        reg_out,
    input  logic              cpu_we_L1,
    input  logic              cpu_we_L2,
    input  logic [ADDR_W-1:0] cpu_abus,
    output logic [ADDR_W-1:0] vram_abus,
    output logic [7:0]        vram_din,
    output logic              vram_we_L1,
    output logic              vram_we_L2,
    output logic              busy,
    output logic              done_irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_RUN,
        S_DONE
    } state_t;

    state_t      state;
    logic [10:0] start;
    logic [10:0] len;
    logic [7:0]  fill;
    logic        layer;
    logic        both;
    logic        inc;
    logic [10:0] cur;
    logic [10:0] rem;
    logic [7:0]  val;
    logic        done_flag;
    logic        err_flag;
    logic        abt_flag;

    logic        reg_wr;
    logic        ctrl_wr;
    logic        go;
    logic        abort;
    logic        clr;
    logic        cpu_any;
    logic        dma_wr;
    logic [11:0] span;
    logic        unused_addr;

    assign unused_addr = ^address_bus[15:3];

    assign reg_wr  = dma_cs && !z80_write;
    assign ctrl_wr = reg_wr && (address_bus[2:0] == 3'd5);
    assign abort   = ctrl_wr && data_bus[7];
    assign clr     = ctrl_wr && data_bus[6];
    // ABORT beats GO when both arrive in the same write
    assign go      = ctrl_wr && data_bus[0] && !data_bus[7];
    assign cpu_any = cpu_we_L1 || cpu_we_L2;
    assign dma_wr  = (state == S_RUN) && !cpu_any;
    assign span    = {1'b0, start} + {1'b0, len};
    // busy covers the whole job, including the one-cycle DONE state
    assign busy    = (state != S_IDLE);
    assign done_irq = done_flag;

`ifndef VRAM_DMA_INC_EN
    assign inc = 1'b0;
`endif

    // Parameter registers; frozen while a job is in flight
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            start <= '0;
            len   <= '0;
            fill  <= '0;
            layer <= 1'b0;
            both  <= 1'b0;
`ifdef VRAM_DMA_INC_EN
            inc   <= 1'b0;
`endif
        end else if (reg_wr && !busy) begin
            case (address_bus[2:0])
                3'd0: start[7:0]  <= data_bus;
                3'd1: start[10:8] <= data_bus[2:0];
                3'd2: len[7:0]    <= data_bus;
                3'd3: len[10:8]   <= data_bus[2:0];
                3'd4: fill        <= data_bus;
                3'd5: begin
                    layer <= data_bus[1];
                    both  <= data_bus[2];
`ifdef VRAM_DMA_INC_EN
                    inc   <= data_bus[3];
`endif
                end
                default: ;
            endcase
        end
    end

    // Job FSM: range check, fill loop with CPU-priority stalls, sticky status flags
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cur       <= '0;
            rem       <= '0;
            val       <= '0;
            done_flag <= 1'b0;
            err_flag  <= 1'b0;
            abt_flag  <= 1'b0;
        end else begin
            if (clr) begin
                done_flag <= 1'b0;
                err_flag  <= 1'b0;
                abt_flag  <= 1'b0;
            end
            unique case (state)
                S_IDLE: begin
                    if (go) begin
                        state     <= S_CHECK;
                        done_flag <= 1'b0;
                        err_flag  <= 1'b0;
                        abt_flag  <= 1'b0;
                        cur       <= start;
                        rem       <= len;
                        val       <= fill;
                    end
                end
                S_CHECK: begin
                    if (abort) begin
                        state    <= S_IDLE;
                        abt_flag <= 1'b1;
                    end else if (rem == 11'd0) begin
                        state <= S_DONE;
                    end else if (span > 12'(VRAM_DEPTH)) begin
                        state    <= S_IDLE;
                        err_flag <= 1'b1;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (dma_wr) begin
                        cur <= cur + 11'd1;
                        rem <= rem - 11'd1;
                        if (inc) val <= val + 8'd1;
                    end
                    if (abort) begin
                        state    <= S_IDLE;
                        abt_flag <= 1'b1;
                    end else if (dma_wr && rem == 11'd1) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    done_flag <= 1'b1;
                end
            endcase
        end
    end

    // Write-port mux: CPU always wins, DMA fills only in RUN
    always_comb begin
        vram_abus  = '0;
        vram_din   = '0;
        vram_we_L1 = 1'b0;
        vram_we_L2 = 1'b0;
        if (!rst) begin
            if (cpu_any) begin
                vram_abus  = cpu_abus;
                vram_din   = data_bus;
                vram_we_L1 = cpu_we_L1;
                vram_we_L2 = cpu_we_L2;
            end else if (state == S_RUN) begin
                vram_abus  = ADDR_W'(cur);
                vram_din   = val;
                vram_we_L1 = both || !layer;
                vram_we_L2 = both || layer;
            end
        end
    end

    // Register read-back
    always_comb begin
        reg_out = 8'h00;
        case (address_bus[2:0])
            3'd0: reg_out = start[7:0];
            3'd1: reg_out = {5'd0, start[10:8]};
            3'd2: reg_out = len[7:0];
            3'd3: reg_out = {5'd0, len[10:8]};
            3'd4: reg_out = fill;
            3'd5: reg_out = {4'd0, inc, both, layer, 1'b0};
            3'd6: reg_out = {4'd0, abt_flag, err_flag, done_flag, busy};
            default: reg_out = 8'h00;
        endcase
    end

endmodule
